elixirchip_es1_spu_op_div: RTL
==============================

// Module: elixirchip_es1_spu_op_div
// PURPOSE
//  Fully pipelined signed divider SPU op: m_data = (s_data0 <<< DATA_SHIFT) / s_data1.
//  Inverse companion of spu_op_mul; shares its reset/clk/cke, s_clear/s_valid and m_data contract.
//  Accepts one operation per enabled cycle and produces one quotient per enabled cycle.
//  Restoring division, one quotient bit per stage.
//  Sits in the SPU datapath next to the mul/add ops; driven by the same sequencer.
// PARAMETERS
//  S_DATA0_BITS  8    dividend width (signed)
//  S_DATA1_BITS  8    divisor width (signed)
//  M_DATA_BITS   8    quotient output width (signed)
//  DATA_SHIFT    0    dividend left shift before division (fixed-point scaling, >=0)
//  CLEAR_DATA    '0   m_data value on s_clear and after reset
//  DIV0_DATA     '1   m_data value when s_data1==0
//  DEVICE        "RTL"    target device
//  SIMULATION    "false"  simulation mode
//  DEBUG         "false"  debug mode
//  localparam Q_BITS  = S_DATA0_BITS+DATA_SHIFT
//  localparam LATENCY = Q_BITS+2
// PORTS
//  clk      in   1             clock
//  reset    in   1             synchronous reset, active-high
//  cke      in   1             clock enable; 0 = whole pipeline and outputs frozen
//  s_data0  in   S_DATA0_BITS  dividend
//  s_data1  in   S_DATA1_BITS  divisor
//  s_clear  in   1             clear request (priority over s_valid)
//  s_valid  in   1             operands valid
//  m_data   out  M_DATA_BITS   quotient
//  m_valid  out  1             m_data updated this cycle
// BEHAVIOUR
//  - Timing rule: all state advances only on posedge clk with cke=1.
//  - Reset: all stage valid/clear flags <=0, m_data<=CLEAR_DATA, m_valid<=0.
//    Reset has priority over cke. In-flight ops are discarded, never emitted.
//  - Stage 0 (register, captured when s_valid|s_clear):
//    - latches sign_q = sign0^sign1 and the div0 flag.
//    - latches |s_data0|<<DATA_SHIFT as a Q_BITS unsigned value and |s_data1| as S_DATA1_BITS+1 unsigned.
//    - abs of the most-negative value is computed in widened width, so no overflow.
//  - Stages 1..Q_BITS: shift remainder left, bring in the next dividend MSB, trial-subtract divisor.
//    - non-negative result: keep it, quotient bit=1; else restore, quotient bit=0.
//    - remainder width is S_DATA1_BITS+1.
//  - Final stage:
//    - negate the quotient if sign_q.
//    - truncate/sign-extend Q_BITS+1 -> M_DATA_BITS.
//    - div0 -> DIV0_DATA.
//  - Rounding is toward zero (C semantics); remainder is discarded.
//  - Overflow wraps by truncation (e.g. -128/-1 @8b -> -128).
//  - Output update, on the cycle an op reaches the end after LATENCY enabled cycles:
//    - clear op: m_data<=CLEAR_DATA.
//    - valid op: m_data<=result.
//    - m_valid is 1 for exactly that cycle, else 0.
//  - No op in the last stage: m_data holds its value (stable while !m_valid).
//  - s_clear && s_valid same cycle: treated as clear only.
//  - Back-to-back ops every cycle are allowed; results keep issue order.
//  - No backpressure; no ready signal.
//  - cke=0 mid-stream: every stage, m_data and m_valid hold (m_valid stays at its last value).
// TESTING (8/8/8, DATA_SHIFT=0, LATENCY=10 unless noted)
//  - 100/7 with s_valid=1 for 1 cycle -> m_data=14, m_valid=1 exactly 10 cycles later, then m_data holds.
//  - Sign and overflow cases, back-to-back:
//    - -100/7 -> -14; 100/-7 -> -14; -100/-7 -> 14.
//    - -128/-1 -> -128; -128/1 -> -128.
//  - Divide by zero: 5/0, then -5/0 -> DIV0_DATA (0xFF) both.
//  - Stream of 16 random ops with cke toggling randomly:
//    - each result equals the golden model after 10 enabled cycles.
//    - m_data stable whenever m_valid=0.
//  - Clear and reset:
//    - s_clear+s_valid together -> CLEAR_DATA after 10 enabled cycles.
//    - reset asserted 4 cycles after an op -> no m_valid ever for it; m_data=CLEAR_DATA.
//  - DATA_SHIFT=4 (LATENCY=14): 3/2 -> 24; -1/3 -> -5; 127/1 -> 0xF0 (truncated).

Source files
------------

// File: rtl/elixirchip_es1_spu_op_div.sv
// Pipelined signed restoring divider: m_data = (s_data0 <<< DATA_SHIFT) / s_data1, rounding toward zero.
// One op per enabled cycle; result appears Q_BITS+2 enabled cycles after issue.
module elixirchip_es1_spu_op_div #(
    parameter int                      S_DATA0_BITS = 8,
    parameter int                      S_DATA1_BITS = 8,
    parameter int                      M_DATA_BITS  = 8,
    parameter int                      DATA_SHIFT   = 0,
    parameter logic [M_DATA_BITS-1:0]  CLEAR_DATA   = '0,
    parameter logic [M_DATA_BITS-1:0]  DIV0_DATA    = '1,
    parameter string                   DEVICE       = "RTL",
    parameter string                   SIMULATION   = "false",
    parameter string                   DEBUG        = "false"
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cke,
    input  logic [S_DATA0_BITS-1:0]  s_data0,
    input  logic [S_DATA1_BITS-1:0]  s_data1,
    input  logic                     s_clear,
    input  logic                     s_valid,
    output logic [M_DATA_BITS-1:0]   m_data,
    output logic                     m_valid
);

    localparam int Q_BITS = S_DATA0_BITS + DATA_SHIFT;
    localparam int R_BITS = S_DATA1_BITS + 1;

    // The unsigned reading of the two's-complement negation already holds 2^(N-1) for the most-negative input.
    function automatic logic [S_DATA0_BITS-1:0] abs_dividend(input logic [S_DATA0_BITS-1:0] v);
        if (v[S_DATA0_BITS-1]) begin
            abs_dividend = ~v + S_DATA0_BITS'(1);
        end else begin
            abs_dividend = v;
        end
    endfunction

    function automatic logic [R_BITS-1:0] abs_divisor(input logic [S_DATA1_BITS-1:0] v);
        if (v[S_DATA1_BITS-1]) begin
            abs_divisor = {1'b0, ~v + S_DATA1_BITS'(1)};
        end else begin
            abs_divisor = {1'b0, v};
        end
    endfunction

    logic              stg_valid_r [0:Q_BITS];
    logic              stg_clear_r [0:Q_BITS];
    logic              stg_sign_r  [0:Q_BITS];
    logic              stg_div0_r  [0:Q_BITS];
    logic [Q_BITS-1:0] stg_quo_r   [0:Q_BITS];
    logic [R_BITS-1:0] stg_rem_r   [0:Q_BITS];
    logic [R_BITS-1:0] stg_dvs_r   [0:Q_BITS];

    // Stage 0: operand capture, sign and divide-by-zero detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid_r[0] <= 1'b0;
            stg_clear_r[0] <= 1'b0;
        end else if (cke) begin
            stg_valid_r[0] <= s_valid & ~s_clear;
            stg_clear_r[0] <= s_clear;
            if (s_valid | s_clear) begin
                stg_sign_r[0] <= s_data0[S_DATA0_BITS-1] ^ s_data1[S_DATA1_BITS-1];
                stg_div0_r[0] <= (s_data1 == S_DATA1_BITS'(0));
                stg_quo_r[0]  <= Q_BITS'(abs_dividend(s_data0)) << DATA_SHIFT;
                stg_rem_r[0]  <= R_BITS'(0);
                stg_dvs_r[0]  <= abs_divisor(s_data1);
            end
        end
    end

    // The quotient register doubles as the dividend shifter: MSBs leave as quotient bits enter at the LSB.
    for (genvar i = 1; i <= Q_BITS; i++) begin : g_stage
        logic [R_BITS:0] rem_sh_s;
        logic [R_BITS:0] diff_s;

        // Trial subtraction of the divisor from the shifted remainder.
        always_comb begin
            rem_sh_s = {stg_rem_r[i-1], stg_quo_r[i-1][Q_BITS-1]};
            diff_s   = rem_sh_s - {1'b0, stg_dvs_r[i-1]};
        end

        // Restoring step: keep the difference if non-negative, else keep the shifted remainder.
        always_ff @(posedge clk) begin
            if (reset) begin
                stg_valid_r[i] <= 1'b0;
                stg_clear_r[i] <= 1'b0;
            end else if (cke) begin
                stg_valid_r[i] <= stg_valid_r[i-1];
                stg_clear_r[i] <= stg_clear_r[i-1];
                stg_sign_r[i]  <= stg_sign_r[i-1];
                stg_div0_r[i]  <= stg_div0_r[i-1];
                stg_dvs_r[i]   <= stg_dvs_r[i-1];
                if (!diff_s[R_BITS]) begin
                    stg_rem_r[i] <= diff_s[R_BITS-1:0];
                    stg_quo_r[i] <= {stg_quo_r[i-1][Q_BITS-2:0], 1'b1};
                end else begin
                    stg_rem_r[i] <= rem_sh_s[R_BITS-1:0];
                    stg_quo_r[i] <= {stg_quo_r[i-1][Q_BITS-2:0], 1'b0};
                end
            end
        end
    end

    logic [Q_BITS:0]        quo_ext_s;
    logic [Q_BITS:0]        res_s;
    logic [M_DATA_BITS-1:0] res_m_s;

    // Apply the quotient sign, then wrap/sign-extend to the output width.
    always_comb begin
        quo_ext_s = {1'b0, stg_quo_r[Q_BITS]};
        if (stg_sign_r[Q_BITS]) begin
            res_s = (Q_BITS + 1)'(0) - quo_ext_s;
        end else begin
            res_s = quo_ext_s;
        end
        res_m_s = M_DATA_BITS'($signed(res_s));
    end

    // Output register: m_data holds unless an op completes this enabled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= CLEAR_DATA;
        end else if (cke) begin
            m_valid <= stg_valid_r[Q_BITS] | stg_clear_r[Q_BITS];
            if (stg_clear_r[Q_BITS]) begin
                m_data <= CLEAR_DATA;
            end else if (stg_valid_r[Q_BITS]) begin
                m_data <= stg_div0_r[Q_BITS] ? DIV0_DATA : res_m_s;
            end else begin
                m_data <= m_data;
            end
        end
    end

endmodule
